// File: rtl/wide_mem_loader_pkg.sv
// Shared types and sizing helpers for the wide memory stream loader.
package wide_mem_loader_pkg;

    // Transfer sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_e;

    // Number of byte lanes in one memory word.
    function automatic int bytes_per_word(input int data_width);
        return data_width / 8;
    endfunction

    // Index width for a range of n entries, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_mem_stream_loader_byte_word_packer.sv
// Assembles incoming bytes little-endian into one memory word with strobes.
module byte_word_packer
    import wide_mem_loader_pkg::*;
#(
    parameter int DataWidth = 512,
    localparam int BytesPerWord = bytes_per_word(DataWidth),
    localparam int LaneWidth    = addr_width(BytesPerWord)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    wr_i,
    input  logic                    last_i,
    input  logic [7:0]              byte_i,
    output logic [DataWidth-1:0]    data_o,
    output logic [BytesPerWord-1:0] strb_o,
    output logic                    word_done_o
);

    logic [LaneWidth-1:0]    lane_q, lane_d;
    logic [DataWidth-1:0]    data_q, data_d;
    logic [BytesPerWord-1:0] strb_q, strb_d;
    logic                    lane_full;

    // The byte being written now lands in the top lane.
    assign lane_full   = (lane_q == LaneWidth'(BytesPerWord - 1));
    // The word is complete when the top lane fills or the stream ends early.
    assign word_done_o = wr_i & (lane_full | last_i);

    // Lane pointer advances per byte and returns to lane 0 on clear.
    always_comb begin
        lane_d = lane_q;
        if (clear_i) begin
            lane_d = '0;
        end else if (wr_i) begin
            lane_d = lane_q + LaneWidth'(1);
        end
    end

    // Each lane captures the byte when the pointer addresses it.
    for (genvar gi = 0; gi < BytesPerWord; gi++) begin : g_lane
        logic lane_hit;
        assign lane_hit = wr_i && (lane_q == LaneWidth'(gi));
        assign data_d[8*gi +: 8] = clear_i ? 8'h00 : (lane_hit ? byte_i : data_q[8*gi +: 8]);
        assign strb_d[gi]        = clear_i ? 1'b0  : (lane_hit ? 1'b1   : strb_q[gi]);
    end

    // Assembly registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lane_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            strb_q <= strb_d;
        end
    end

    assign data_o = data_q;
    assign strb_o = strb_q;

endmodule

// File: rtl/wide_mem_stream_loader.sv
// Byte-stream preload engine: packs bytes into wide words and writes them to
// one of several SRAM targets over a req/gnt port.
module wide_mem_stream_loader
    import wide_mem_loader_pkg::*;
#(
    parameter int DataWidth  = 512,
    parameter int Depth      = 16384,
    parameter int NumTargets = 4,
    parameter int LenWidth   = 32,
    localparam int BytesPerWord = bytes_per_word(DataWidth),
    localparam int AddrWidth    = addr_width(Depth),
    localparam int TgtWidth     = addr_width(NumTargets)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [AddrWidth-1:0]    base_addr_i,
    input  logic [LenWidth-1:0]     len_bytes_i,
    input  logic [TgtWidth-1:0]     target_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [7:0]              in_data_i,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic [NumTargets-1:0]   mem_sel_o,
    output logic [AddrWidth-1:0]    mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BytesPerWord-1:0] mem_strb_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o
);

    // Wide enough that base + word count can never wrap during the check.
    localparam int CheckWidth = LenWidth + AddrWidth + 2;

    // The request bundle's widths follow this instance's parameters.
    typedef struct packed {
        logic [NumTargets-1:0]   sel;
        logic [AddrWidth-1:0]    addr;
        logic [DataWidth-1:0]    wdata;
        logic [BytesPerWord-1:0] strb;
    } mem_req_t;

    loader_state_e           state_q, state_d;
    logic                    err_q, err_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [LenWidth-1:0]     len_q, len_d;
    logic [LenWidth-1:0]     cnt_q, cnt_d;
    logic [TgtWidth-1:0]     tgt_q, tgt_d;

    logic                    pk_clear, pk_wr, pk_last, pk_word_done;
    logic [DataWidth-1:0]    pk_data;
    logic [BytesPerWord-1:0] pk_strb;

    logic [CheckWidth-1:0]   words_needed, span_end;
    logic                    start_len_zero, start_bad_target, start_overflow;
    logic [NumTargets-1:0]   sel_onehot;
    mem_req_t                mem_bus;

    // Start legality: the whole span must fit so the address never wraps.
    assign words_needed     = (CheckWidth'(len_bytes_i) + CheckWidth'(BytesPerWord - 1))
                              / CheckWidth'(BytesPerWord);
    assign span_end         = CheckWidth'(base_addr_i) + words_needed;
    assign start_overflow   = (span_end > CheckWidth'(Depth));
    assign start_bad_target = ({1'b0, target_i} >= (TgtWidth + 1)'(NumTargets));
    assign start_len_zero   = (len_bytes_i == '0);

    // The byte being accepted now is the final byte of the transfer.
    assign pk_last = ((cnt_q + LenWidth'(1)) == len_q);

    byte_word_packer #(
        .DataWidth(DataWidth)
    ) u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (pk_clear),
        .wr_i       (pk_wr),
        .last_i     (pk_last),
        .byte_i     (in_data_i),
        .data_o     (pk_data),
        .strb_o     (pk_strb),
        .word_done_o(pk_word_done)
    );

    // Next-state, counters and handshake outputs; abort overrides FILL/WRITE.
    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        addr_d     = addr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        pk_clear   = 1'b0;
        pk_wr      = 1'b0;
        in_ready_o = 1'b0;
        mem_req_o  = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (start_len_zero) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else if (start_bad_target || start_overflow) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        addr_d   = base_addr_i;
                        len_d    = len_bytes_i;
                        tgt_d    = target_i;
                        cnt_d    = '0;
                        pk_clear = 1'b1;
                        state_d  = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                in_ready_o = 1'b1;
                if (abort_i) begin
                    pk_clear = 1'b1;
                    state_d  = ST_IDLE;
                end else if (in_valid_i) begin
                    pk_wr = 1'b1;
                    cnt_d = cnt_q + LenWidth'(1);
                    if (pk_word_done) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                mem_req_o = 1'b1;
                if (abort_i) begin
                    pk_clear = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mem_gnt_i) begin
                    pk_clear = 1'b1;
                    addr_d   = addr_q + AddrWidth'(1);
                    state_d  = (cnt_q == len_q) ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    // One-hot target decode of the latched selection.
    for (genvar gi = 0; gi < NumTargets; gi++) begin : g_sel
        assign sel_onehot[gi] = (tgt_q == TgtWidth'(gi));
    end

    // Select only asserts alongside a request; the rest come from registers.
    assign mem_bus.sel   = mem_req_o ? sel_onehot : '0;
    assign mem_bus.addr  = addr_q;
    assign mem_bus.wdata = pk_data;
    assign mem_bus.strb  = pk_strb;

    assign mem_sel_o   = mem_bus.sel;
    assign mem_addr_o  = mem_bus.addr;
    assign mem_wdata_o = mem_bus.wdata;
    assign mem_strb_o  = mem_bus.strb;
    assign busy_o      = (state_q != ST_IDLE);
    assign err_o       = err_q;

endmodule
